// File: rtl/execute_hazard_controller_if.sv
// Pipeline-side bundle for execute_hazard_controller: DECODE/EXECUTE status in, stall/flush/bubble enables out.
// master = pipeline datapath, slave = hazard controller.
interface execute_hazard_controller_if #(
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  valid_DECODE_i;
  logic                  uses_reg_1_DECODE_i;
  logic                  uses_reg_2_DECODE_i;
  logic [ADDR_WIDTH-1:0] reg_addr_1_DECODE_i;
  logic [ADDR_WIDTH-1:0] reg_addr_2_DECODE_i;
  logic                  multicycle_DECODE_i;
  logic                  mem_read_EX_i;
  logic                  reg_write_EX_i;
  logic [ADDR_WIDTH-1:0] reg_dest_EX_i;
  logic                  branch_taken_EX_i;
  logic                  stall_FETCH_o;
  logic                  stall_DECODE_o;
  logic                  flush_DECODE_o;
  logic                  bubble_EX_o;
  logic                  hold_EX_o;
  logic                  bubble_MEM_o;
  logic                  mc_done_o;

  modport master (
    output valid_DECODE_i, uses_reg_1_DECODE_i, uses_reg_2_DECODE_i,
           reg_addr_1_DECODE_i, reg_addr_2_DECODE_i, multicycle_DECODE_i,
           mem_read_EX_i, reg_write_EX_i, reg_dest_EX_i, branch_taken_EX_i,
    input  stall_FETCH_o, stall_DECODE_o, flush_DECODE_o, bubble_EX_o,
           hold_EX_o, bubble_MEM_o, mc_done_o
  );

  modport slave (
    input  valid_DECODE_i, uses_reg_1_DECODE_i, uses_reg_2_DECODE_i,
           reg_addr_1_DECODE_i, reg_addr_2_DECODE_i, multicycle_DECODE_i,
           mem_read_EX_i, reg_write_EX_i, reg_dest_EX_i, branch_taken_EX_i,
    output stall_FETCH_o, stall_DECODE_o, flush_DECODE_o, bubble_EX_o,
           hold_EX_o, bubble_MEM_o, mc_done_o
  );
endinterface

// File: rtl/execute_hazard_controller.sv
// Execute-stage sequencer: load-use bubbles, taken-branch flush, multi-cycle (MUL) hold of EXECUTE.
// Optional HAZARD_PERF_COUNTERS_EN adds saturating stall_cycles_o / flush_count_o counters.
module execute_hazard_controller #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  execute_hazard_controller_if.slave bus
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [31:0]                stall_cycles_o,
  output logic [31:0]                flush_count_o
`endif
);

  typedef enum logic {RUN, MC_BUSY} state_t;

  localparam bit         MC_EN   = (MUL_CYCLES > 1);
  localparam logic [3:0] MC_LOAD = 4'(MUL_CYCLES - 1);

  state_t                state;
  logic [3:0]            mc_cnt;
  logic [ADDR_WIDTH-1:0] dest;
  logic                  lu_hazard;
  logic                  mc_start;
  logic                  stall_fetch;
  logic                  stall_decode;
  logic                  flush_decode;
  logic                  bubble_ex;
  logic                  hold_ex;
  logic                  bubble_mem;
  logic                  mc_done;

  assign dest = bus.reg_dest_EX_i;

  always_comb begin
    lu_hazard = bus.valid_DECODE_i & bus.mem_read_EX_i & bus.reg_write_EX_i &
                ((bus.uses_reg_1_DECODE_i & (bus.reg_addr_1_DECODE_i == dest)) |
                 (bus.uses_reg_2_DECODE_i & (bus.reg_addr_2_DECODE_i == dest)));
    // A MUL only enters EX when neither a flush nor a load-use bubble takes priority.
    mc_start  = MC_EN & bus.valid_DECODE_i & bus.multicycle_DECODE_i &
                ~bus.branch_taken_EX_i & ~lu_hazard;
  end

  always_comb begin
    stall_fetch  = 1'b0;
    stall_decode = 1'b0;
    flush_decode = 1'b0;
    bubble_ex    = 1'b0;
    hold_ex      = 1'b0;
    bubble_mem   = 1'b0;
    mc_done      = 1'b0;
    if (!rst_i) begin
      unique case (state)
        RUN: begin
          if (bus.branch_taken_EX_i) begin
            flush_decode = 1'b1;
            bubble_ex    = 1'b1;
          end else if (lu_hazard) begin
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            bubble_ex    = 1'b1;
          end
        end
        MC_BUSY: begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
          hold_ex      = 1'b1;
          bubble_mem   = 1'b1;
          mc_done      = (mc_cnt == 4'd1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (mc_start) begin
            state  <= MC_BUSY;
            mc_cnt <= MC_LOAD;
          end
        end
        MC_BUSY: begin
          mc_cnt <= mc_cnt - 4'd1;
          if (mc_cnt == 4'd1) state <= RUN;
        end
        default: begin
          state  <= RUN;
          mc_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.stall_FETCH_o  = stall_fetch;
  assign bus.stall_DECODE_o = stall_decode;
  assign bus.flush_DECODE_o = flush_decode;
  assign bus.bubble_EX_o    = bubble_ex;
  assign bus.hold_EX_o      = hold_ex;
  assign bus.bubble_MEM_o   = bubble_mem;
  assign bus.mc_done_o      = mc_done;

`ifdef HAZARD_PERF_COUNTERS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if (stall_decode && (stall_cycles_o != '1)) stall_cycles_o <= stall_cycles_o + 32'd1;
      if (flush_decode && (flush_count_o  != '1)) flush_count_o  <= flush_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_execute_hazard_controller.sv
// Scoreboard bench: two controllers (MUL_CYCLES=4 and MUL_CYCLES=2) driven by directed per-cycle vectors.
module tb_execute_hazard_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  execute_hazard_controller_if #(.ADDR_WIDTH(4)) if_a ();
  execute_hazard_controller_if #(.ADDR_WIDTH(4)) if_b ();

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;
`endif

  execute_hazard_controller #(.ADDR_WIDTH(4), .MUL_CYCLES(4)) dut_a (
    .clk_i (clk),
    .rst_i (rst_a),
    .bus   (if_a)
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    .stall_cycles_o (stall_cnt_a),
    .flush_count_o  (flush_cnt_a)
`endif
  );

  execute_hazard_controller #(.ADDR_WIDTH(4), .MUL_CYCLES(2)) dut_b (
    .clk_i (clk),
    .rst_i (rst_b),
    .bus   (if_b)
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    .stall_cycles_o (stall_cnt_b),
    .flush_count_o  (flush_cnt_b)
`endif
  );

  // Output vector order: stall_FETCH, stall_DECODE, flush_DECODE, bubble_EX, hold_EX, bubble_MEM, mc_done
  logic [6:0] out_a, out_b;
  assign out_a = {if_a.stall_FETCH_o, if_a.stall_DECODE_o, if_a.flush_DECODE_o, if_a.bubble_EX_o,
                  if_a.hold_EX_o, if_a.bubble_MEM_o, if_a.mc_done_o};
  assign out_b = {if_b.stall_FETCH_o, if_b.stall_DECODE_o, if_b.flush_DECODE_o, if_b.bubble_EX_o,
                  if_b.hold_EX_o, if_b.bubble_MEM_o, if_b.mc_done_o};

  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_STALL = 7'b1101000;
  localparam logic [6:0] O_FLUSH = 7'b0011000;
  localparam logic [6:0] O_BUSY  = 7'b1100110;
  localparam logic [6:0] O_DONE  = 7'b1100111;

  typedef struct {
    bit         sel;
    logic [6:0] exp;
    string      name;
  } sb_entry_t;

  sb_entry_t sbq[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic step(input bit sel, input logic rst, input logic valid,
                      input logic u1, input logic [3:0] a1, input logic u2, input logic [3:0] a2,
                      input logic mc, input logic mr, input logic rw, input logic [3:0] dest,
                      input logic br, input logic [6:0] exp, input string name);
    sb_entry_t e;
    @(posedge clk);
    #1;
    if (!sel) begin
      rst_a = rst;
      if_a.valid_DECODE_i = valid;      if_a.uses_reg_1_DECODE_i = u1;
      if_a.reg_addr_1_DECODE_i = a1;    if_a.uses_reg_2_DECODE_i = u2;
      if_a.reg_addr_2_DECODE_i = a2;    if_a.multicycle_DECODE_i = mc;
      if_a.mem_read_EX_i = mr;          if_a.reg_write_EX_i = rw;
      if_a.reg_dest_EX_i = dest;        if_a.branch_taken_EX_i = br;
    end else begin
      rst_b = rst;
      if_b.valid_DECODE_i = valid;      if_b.uses_reg_1_DECODE_i = u1;
      if_b.reg_addr_1_DECODE_i = a1;    if_b.uses_reg_2_DECODE_i = u2;
      if_b.reg_addr_2_DECODE_i = a2;    if_b.multicycle_DECODE_i = mc;
      if_b.mem_read_EX_i = mr;          if_b.reg_write_EX_i = rw;
      if_b.reg_dest_EX_i = dest;        if_b.branch_taken_EX_i = br;
    end
    e.sel = sel; e.exp = exp; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic idle_all();
    rst_a = 1'b1; rst_b = 1'b1;
    if_a.valid_DECODE_i = 0; if_a.uses_reg_1_DECODE_i = 0; if_a.reg_addr_1_DECODE_i = '0;
    if_a.uses_reg_2_DECODE_i = 0; if_a.reg_addr_2_DECODE_i = '0; if_a.multicycle_DECODE_i = 0;
    if_a.mem_read_EX_i = 0; if_a.reg_write_EX_i = 0; if_a.reg_dest_EX_i = '0; if_a.branch_taken_EX_i = 0;
    if_b.valid_DECODE_i = 0; if_b.uses_reg_1_DECODE_i = 0; if_b.reg_addr_1_DECODE_i = '0;
    if_b.uses_reg_2_DECODE_i = 0; if_b.reg_addr_2_DECODE_i = '0; if_b.multicycle_DECODE_i = 0;
    if_b.mem_read_EX_i = 0; if_b.reg_write_EX_i = 0; if_b.reg_dest_EX_i = '0; if_b.branch_taken_EX_i = 0;
  endtask

  // Monitor: outputs are combinational, so each cycle's vector is checked mid-cycle.
  initial begin
    sb_entry_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        act = e.sel ? out_b : out_a;
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned drain;
    idle_all();
    // sel, rst, valid, u1, a1, u2, a2, mc, mr, rw, dest, br, exp, name
    step(0, 1, 1, 1, 4'd3, 1, 4'd3, 1, 1, 1, 4'd3, 1, O_IDLE, "a_reset_forces_zero");
    step(0, 1, 1, 1, 4'd3, 1, 4'd3, 1, 1, 1, 4'd3, 1, O_IDLE, "a_reset_hold");
    step(0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0, O_IDLE, "a_idle_after_reset");
    step(0, 0, 1, 1, 4'd5, 1, 4'd3, 0, 1, 1, 4'd3, 0, O_STALL, "a_lu_src2");
    step(0, 0, 1, 1, 4'd5, 1, 4'd3, 0, 0, 1, 4'd9, 0, O_IDLE, "a_lu_released");
    step(0, 0, 1, 1, 4'd5, 0, 4'd3, 0, 1, 1, 4'd3, 0, O_IDLE, "a_no_use_reg2");
    step(0, 0, 1, 1, 4'd5, 1, 4'd3, 0, 1, 0, 4'd3, 0, O_IDLE, "a_no_reg_write");
    step(0, 0, 1, 1, 4'd7, 0, 4'd2, 0, 1, 1, 4'd7, 0, O_STALL, "a_lu_src1");
    step(0, 0, 0, 1, 4'd7, 1, 4'd7, 1, 1, 1, 4'd7, 0, O_IDLE, "a_invalid_suppresses");
    step(0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 1, O_FLUSH, "a_branch_invalid_decode");
    step(0, 0, 1, 1, 4'd4, 1, 4'd4, 1, 1, 1, 4'd4, 1, O_FLUSH, "a_branch_priority");
    step(0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0, O_IDLE, "a_run_after_branch");
    step(0, 0, 1, 1, 4'd1, 1, 4'd2, 1, 0, 1, 4'd6, 0, O_IDLE, "a_mul_issue");
    step(0, 0, 1, 1, 4'd6, 0, 4'd0, 0, 1, 1, 4'd6, 1, O_BUSY, "a_busy1_ignores_br_lu");
    step(0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0, O_BUSY, "a_busy2");
    step(0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0, O_DONE, "a_busy3_done");
    step(0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0, O_IDLE, "a_run_after_mul");
    step(0, 0, 1, 0, 4'd0, 0, 4'd0, 1, 0, 0, 4'd0, 0, O_IDLE, "a_mul2_issue");
    step(0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0, O_BUSY, "a_mul2_busy1");
    step(0, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0, O_IDLE, "a_reset_in_busy");
    step(0, 0, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0, O_IDLE, "a_run_after_abort");
`ifdef HAZARD_PERF_COUNTERS_EN
    @(negedge clk);
    #1;
    checks++;
    if (stall_cnt_a !== 32'd0 || flush_cnt_a !== 32'd0) begin
      errors++;
      $display("FAIL a_counters_after_reset: got stall=%0d flush=%0d expected 0 0", stall_cnt_a, flush_cnt_a);
    end
`endif
    step(0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 1, O_FLUSH, "a_branch_after_abort");

    step(1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0, O_IDLE, "b_reset");
    step(1, 0, 1, 0, 4'd0, 0, 4'd0, 1, 0, 0, 4'd0, 0, O_IDLE, "b_mul1_issue");
    step(1, 0, 1, 0, 4'd0, 0, 4'd0, 1, 0, 0, 4'd0, 0, O_DONE, "b_mul1_busy_done");
    step(1, 0, 1, 0, 4'd0, 0, 4'd0, 1, 0, 0, 4'd0, 0, O_IDLE, "b_mul2_issue_no_gap");
    step(1, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0, O_DONE, "b_mul2_busy_done");
    step(1, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0, O_IDLE, "b_run_after");

    drain = 0;
    while (sbq.size() > 0 && drain < 10) begin
      @(negedge clk);
      #1;
      drain++;
    end
    if (sbq.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
